pipeline_muldiv_ctrl: RTL
=========================

# pipeline_muldiv_ctrl

Iterative multiply/divide controller that sits beside the EX stage. It sequences one shared shift-add/restoring-divide datapath for MULT/MULTU/DIV/DIVU and owns the architectural HI/LO registers. It takes the post-forwarding EX operands and raises a stall to the pipeline hazard logic whenever an EX instruction needs HI/LO, or the unit itself, while an operation is in flight.

## Interface
- No parameters; the datapath width is fixed at 32 bits.
- clk  in  1  pipeline clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- EX_MDOp  in  3  operation of the instruction in EX:
  - 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO.
  - 111 is treated as none.
- EX_MDRead  in  2  00 none, 01 MFHI, 10 MFLO, 11 treated as none.
- EX_MDValid  in  1  the EX instruction is real (not a bubble, not flushed).
- EX_Data1  in  32  post-forward rs operand (dividend / multiplicand / MT source).
- EX_Data2  in  32  post-forward rt operand (divisor / multiplier).
- MD_Stall  out  1  hold IF/ID/EX and insert a bubble into MEM (combinational).
- MD_Busy  out  1  unit is in BUSY or FIX.
- MD_ReadData  out  32  HI when EX_MDRead=01, LO when 10, otherwise 0 (combinational).
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.

## Operation
- **States:** IDLE, BUSY (iterations), FIX (sign correction and writeback). 5-bit iteration counter `cnt`.
- **Request:** req = EX_MDValid & (EX_MDOp != none or EX_MDRead != none).
- **Stall:** MD_Stall = MD_Busy & req. The instruction that issues a MULT/DIV is never stalled; only later users of the unit stall.
- **Issue (IDLE, valid MULT/MULTU/DIV/DIVU):**
  - Latch |Data1| and |Data2| (signed ops) or the raw operands (unsigned ops).
  - Latch the result sign: XOR of the operand signs for the product and quotient; Data1 sign for the remainder.
  - Latch the op type, clear cnt, go to BUSY.
- **MTHI/MTLO (IDLE, valid):** write Data1 to HI or LO at the edge; stay in IDLE.
- **BUSY:** one iteration per cycle.
  - Multiply: 64-bit shift-add, one multiplier bit per cycle.
  - Divide: restoring divide, one quotient bit per cycle.
  - At cnt=31, go to FIX.
- **FIX:** apply two's-complement negation where the latched signs require it, write HI/LO at the edge, go to IDLE.
  - MULT/MULTU: {HI,LO} = 64-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder.
- **Divide by zero (Data2=0):** result is LO=0xFFFFFFFF, HI=Data1 (the original operand). Cycle count is unchanged.
- **DIV 0x80000000 / 0xFFFFFFFF:** result is LO=0x80000000, HI=0.
- **Conflicting inputs:** EX_MDOp and EX_MDRead both nonzero is illegal; EX_MDOp takes effect and MD_ReadData still shows the pre-edge HI/LO.
- **EX_MDValid=0:** no state change and no stall.

## Timing
- **Reset values:** state IDLE, cnt=0, HI=0, LO=0, MD_Busy=0, MD_Stall=0, MD_ReadData=0.
- **Latency:** an op issued in cycle N (IDLE) gives BUSY in cycles N+1..N+32 and FIX in N+33. New HI/LO are visible from N+34. MD_Busy is high in N+1..N+33.
- **MFHI/MFLO in EX during N+1..N+33:** stalled. MD_Stall drops in N+34 and MD_ReadData returns the new value in that same cycle.
- **New MULT/DIV/MTHI/MTLO arriving while busy:** stalled until IDLE, then issues in the first IDLE cycle.
- **Back-to-back issue:** a new op can issue in the same cycle the unit returns to IDLE (N+34).
- **Reset mid-operation:** asserting reset in any state forces IDLE immediately. The in-flight result is discarded and HI/LO clear to 0.
- **Operands during BUSY:** only the latched copies are used, so EX_Data1/EX_Data2 changes during BUSY have no effect.

## Test plan
- **Reset then MFHI:** reset, then MFHI valid -> MD_ReadData=0, MD_Stall=0.
- **MULT with negative operand:** MULT 0xFFFFFFFE × 0x00000003 in cycle N -> in N+34, HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- **Signed DIV and dependent MFLO:**
  - Stimulus: DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - MFLO held in EX from N+1: MD_Stall is high for exactly 33 cycles and MD_ReadData=0xFFFFFFFD in N+34.
- **Divide corner cases:** DIVU 0x12345678 / 0 -> LO=0xFFFFFFFF, HI=0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- **MT writes and MT while busy:**
  - In IDLE: MTHI 0xDEADBEEF then MFHI next cycle -> 0xDEADBEEF with no stall.
  - MTLO during BUSY stalls until N+34, then writes LO.
- **Reset mid-operation and invalid requests:** assert reset at N+10 of a MULT -> MD_Busy=0, HI=LO=0 immediately. A following MFLO does not stall. EX_MDValid=0 with EX_MDOp=MULT -> no state change.

Source files
------------

// File: rtl/pipeline_muldiv_ctrl.sv
// Iterative multiply/divide controller beside EX: sequences a shared shift-add /
// restoring-divide datapath, owns HI/LO, and stalls later users while busy.
module pipeline_muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  EX_MDOp,
  input  logic [1:0]  EX_MDRead,
  input  logic        EX_MDValid,
  input  logic [31:0] EX_Data1,
  input  logic [31:0] EX_Data2,
  output logic        MD_Stall,
  output logic        MD_Busy,
  output logic [31:0] MD_ReadData,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_e;
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  state_e      state, next_state;
  logic [4:0]  cnt;
  logic [63:0] p;
  logic [31:0] opb;
  logic [31:0] d1_raw;
  logic        neg_res, neg_rem, is_div;

  logic        op_mult, op_div, op_signed, op_arith;
  logic        rd_hi, rd_lo, req, issue;
  logic [31:0] abs1, abs2;
  logic [32:0] mul_sum, div_trial;
  logic [63:0] mul_next, div_next, p_neg;
  logic [31:0] fix_hi, fix_lo;

  always_comb begin
    op_mult   = (EX_MDOp == OP_MULT) || (EX_MDOp == OP_MULTU);
    op_div    = (EX_MDOp == OP_DIV)  || (EX_MDOp == OP_DIVU);
    op_signed = (EX_MDOp == OP_MULT) || (EX_MDOp == OP_DIV);
    op_arith  = op_mult || op_div;
    rd_hi     = (EX_MDRead == 2'b01);
    rd_lo     = (EX_MDRead == 2'b10);
    req       = EX_MDValid && (((EX_MDOp != OP_NONE) && (EX_MDOp != OP_RSVD)) || rd_hi || rd_lo);
    issue     = (state == S_IDLE) && EX_MDValid && op_arith;
    abs1      = (op_signed && EX_Data1[31]) ? -EX_Data1 : EX_Data1;
    abs2      = (op_signed && EX_Data2[31]) ? -EX_Data2 : EX_Data2;
  end

  assign MD_Busy     = (state != S_IDLE);
  assign MD_Stall    = MD_Busy && req;
  assign MD_ReadData = rd_hi ? HI : (rd_lo ? LO : '0);

  // p holds {partial product, multiplier} or {remainder, dividend->quotient}
  always_comb begin
    mul_sum   = {1'b0, p[63:32]} + (p[0] ? {1'b0, opb} : '0);
    mul_next  = {mul_sum, p[31:1]};
    div_trial = {p[63:32], p[31]} - {1'b0, opb};
    div_next  = div_trial[32] ? {p[62:0], 1'b0} : {div_trial[31:0], p[30:0], 1'b1};
    p_neg     = -p;
    if (!is_div) begin
      fix_hi = neg_res ? p_neg[63:32] : p[63:32];
      fix_lo = neg_res ? p_neg[31:0]  : p[31:0];
    end else if (opb == '0) begin
      fix_hi = d1_raw;
      fix_lo = '1;
    end else begin
      fix_hi = neg_rem ? -p[63:32] : p[63:32];
      fix_lo = neg_res ? -p[31:0]  : p[31:0];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (issue) next_state = S_BUSY;
      S_BUSY:  if (cnt == 5'd31) next_state = S_FIX;
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      p       <= '0;
      opb     <= '0;
      d1_raw  <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      is_div  <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            cnt     <= '0;
            is_div  <= op_div;
            d1_raw  <= EX_Data1;
            neg_res <= op_signed && (EX_Data1[31] ^ EX_Data2[31]);
            neg_rem <= op_signed && EX_Data1[31];
            // multiplicand sits in opb for MULT; divisor sits in opb for DIV
            opb     <= op_div ? abs2 : abs1;
            p       <= {32'd0, op_div ? abs1 : abs2};
          end else if (EX_MDValid && (EX_MDOp == OP_MTHI)) begin
            HI <= EX_Data1;
          end else if (EX_MDValid && (EX_MDOp == OP_MTLO)) begin
            LO <= EX_Data1;
          end
        end
        S_BUSY: begin
          p   <= is_div ? div_next : mul_next;
          cnt <= cnt + 5'd1;
        end
        S_FIX: begin
          HI <= fix_hi;
          LO <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule
